parking_gate_arbiter: RTL
=========================

# parking_gate_arbiter

Shares a single barrier gate between an entry lane and an exit lane of the smart-parking system. It tracks lot occupancy against capacity and refuses entry when the lot is full. It grants the gate to one lane at a time, holds it open until the vehicle passes or a timeout expires, then enforces a closing guard interval. It sits between the per-lane password/sensor controllers and the barrier motor driver.

## Interface
- CAPACITY, 8: number of parking slots; must satisfy 1 ≤ CAPACITY ≤ 2^CNT_W − 1.
- CNT_W, 4: occupancy counter width.
- OPEN_CYCLES, 16: maximum cycles the gate stays open waiting for a pass; must be ≥ 2.
- GUARD_CYCLES, 4: cycles the gate stays closed before the next grant; must be ≥ 1.
- TMR_W, 5: timer width; must hold max(OPEN_CYCLES, GUARD_CYCLES).

- clock_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- entry_req  in  1  level; the entry lane's controller has validated the vehicle.
- exit_req  in  1  level; the exit lane has a vehicle waiting.
- entry_pass  in  1  one-cycle pulse; the vehicle cleared the entry sensor.
- exit_pass  in  1  one-cycle pulse; the vehicle cleared the exit sensor.
- entry_grant  out  1  the gate is open for the entry lane.
- exit_grant  out  1  the gate is open for the exit lane.
- gate_open  out  1  barrier motor command; equals entry_grant | exit_grant.
- occupancy  out  CNT_W  number of vehicles currently in the lot.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- timeout_err  out  1  one-cycle pulse; a grant expired without a pass.

## Operation
- States: IDLE, OPEN_ENTRY, OPEN_EXIT, GUARD. Reset state is IDLE.
- IDLE arbitration uses the requests eligible this cycle:
  - Entry is eligible when entry_req && !full.
  - Exit is eligible when exit_req.
  - If both are eligible, the lane not served last wins. last_served resets to "exit", so entry wins the first tie.
  - If only one is eligible, that lane goes to OPEN_ENTRY or OPEN_EXIT.
  - If none is eligible, the block stays in IDLE.
- In OPEN_x, the timer counts from 0:
  - A matching pass pulse goes to GUARD and updates occupancy: entry +1, exit −1.
  - Exit at occupancy 0 saturates at 0; entry never exceeds CAPACITY, because entry is not granted when full.
  - When the timer reaches OPEN_CYCLES−1 with no pass, timeout_err pulses, occupancy is unchanged, and the block goes to GUARD.
  - The other lane's pass pulse is ignored.
- GUARD holds the gate closed for GUARD_CYCLES cycles, then returns to IDLE.
- Pass pulses in IDLE or GUARD are ignored.
- Requests are level inputs; the block does not latch them. A request dropped before IDLE samples it is lost.
- full and empty are decoded combinationally from the occupancy register.

## Timing
- Reset values: state IDLE, occupancy 0, all grants 0, gate_open 0, timeout_err 0, empty 1, full 0, timer 0.
- Grant latency: a request sampled in IDLE at edge N drives the grant high from edge N+1.
- A pass sampled at edge M:
  - Grant drops and occupancy updates at M+1.
  - GUARD runs for the cycles M+1 through M+GUARD_CYCLES.
  - The earliest next grant is at M+GUARD_CYCLES+1.
- Timeout: with no pass, the grant is high for exactly OPEN_CYCLES cycles. timeout_err is high in the first GUARD cycle.
- A pass in the same cycle as the timeout expiry counts as a pass: occupancy updates and timeout_err stays 0.
- Asynchronous reset mid-grant:
  - Immediately forces gate_open to 0 and occupancy to 0.
  - No pass or timeout is recorded.

## Structure
- Shared package parking_pkg holds the state enum (2-bit encoding) and the default values of CAPACITY, OPEN_CYCLES and GUARD_CYCLES. Other parking blocks use the same package.
- One sub-module, gate_timer:
  - Contents: a TMR_W counter with load/clear, enable and an expire output at a programmable terminal count.
  - Instantiated once; used for both the open window and the guard window.
- The FSM, arbitration and occupancy counter live in the top module.

## Test plan
- Reset, entry_req=1, entry_pass at the 3rd grant cycle → entry_grant is high from the cycle after the request; occupancy becomes 1; gate is closed for 4 cycles; empty=0.
- 8 entries to fill the lot, then entry_req=1 for 50 cycles → full=1, entry_grant never asserts; exit_req plus exit_pass → occupancy=7, then entry is granted.
- entry_req and exit_req both held, each grant completed with a pass → grants alternate: entry, exit, entry, exit.
- entry_req with no pass → grant high for exactly 16 cycles; timeout_err pulses once; occupancy is unchanged.
- exit_req plus exit_pass at occupancy 0 → occupancy stays 0; exit_pass while entry is granted → ignored, grant stays high.
- rst_in low for 1 cycle during OPEN_EXIT with occupancy 5 → gate_open=0 and occupancy=0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared types and default timing/capacity values for the smart-parking blocks.
// Contents: gate FSM state enum (2-bit) and default CAPACITY/OPEN_CYCLES/GUARD_CYCLES.
package parking_pkg;
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      OPEN_ENTRY = 2'd1,
      OPEN_EXIT  = 2'd2,
      GUARD      = 2'd3
   } gate_state_t;
   localparam int CAPACITY_DEF     = 8;
   localparam int OPEN_CYCLES_DEF  = 16;
   localparam int GUARD_CYCLES_DEF = 4;
endpackage

// File: rtl/parking_gate_arbiter_if.sv
// parking_gate_arbiter_if: lane handshake and status bundle between lane controllers and the gate arbiter.
// Lane side (master) drives entry/exit requests and pass pulses; the arbiter (slave) drives
// grants, gate_open, occupancy, full, empty and timeout_err.
interface parking_gate_arbiter_if #(
   parameter int CNT_W = 4
);
   logic             entry_req;
   logic             exit_req;
   logic             entry_pass;
   logic             exit_pass;
   logic             entry_grant;
   logic             exit_grant;
   logic             gate_open;
   logic [CNT_W-1:0] occupancy;
   logic             full;
   logic             empty;
   logic             timeout_err;
   modport master (
      output entry_req, exit_req, entry_pass, exit_pass,
      input  entry_grant, exit_grant, gate_open, occupancy, full, empty, timeout_err
   );
   modport slave (
      input  entry_req, exit_req, entry_pass, exit_pass,
      output entry_grant, exit_grant, gate_open, occupancy, full, empty, timeout_err
   );
endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// gate_timer: up-counter with clear and enable that flags when it sits on a programmable terminal count.
// Ports: clock_in/rst_in (async active-low), clear (sync zero), enable (count up),
// terminal (count at which expire asserts), expire (enable && count == terminal).
module gate_timer #(
   parameter int TMR_W = 5
)(
   input  logic             clock_in,
   input  logic             rst_in,
   input  logic             clear,
   input  logic             enable,
   input  logic [TMR_W-1:0] terminal,
   output logic             expire
);
   logic [TMR_W-1:0] count;
   always_ff @(posedge clock_in or negedge rst_in)
      if (!rst_in) count <= '0;
      else if (clear) count <= '0;
      else if (enable) count <= count + 1'b1;
   assign expire = enable && count == terminal;
endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry and exit lanes and tracks lot occupancy.
// Ports: clock_in, rst_in (async active-low), bus (parking_gate_arbiter_if.slave: requests and
// pass pulses in; grants, gate_open, occupancy, full, empty, timeout_err out).
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY     = CAPACITY_DEF,
   parameter int CNT_W        = 4,
   parameter int OPEN_CYCLES  = OPEN_CYCLES_DEF,
   parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
   parameter int TMR_W        = 5
)(
   input  logic                 clock_in,
   input  logic                 rst_in,
   parking_gate_arbiter_if.slave bus
);
   gate_state_t      state, state_nx;
   logic [CNT_W-1:0] occ, occ_nx;
   logic             last_entry, last_entry_nx;
   logic             timeout_q, timeout_nx;
   logic             full, pick_entry, arb, tmr_exp;
   logic [TMR_W-1:0] tmr_term;
   assign full = occ == CNT_W'(CAPACITY);
   // Entry wins when it is eligible and either exit is idle or exit was served last.
   assign pick_entry = bus.entry_req && !full && (!bus.exit_req || !last_entry);
   // The last guard cycle doubles as the arbitration cycle so the next grant lands right after guard.
   assign arb = state == IDLE || (state == GUARD && tmr_exp);
   assign tmr_term = state == GUARD ? TMR_W'(GUARD_CYCLES - 1) : TMR_W'(OPEN_CYCLES - 1);
   gate_timer #(.TMR_W(TMR_W)) u_timer (
      .clock_in (clock_in),
      .rst_in   (rst_in),
      .clear    (state_nx != state),
      .enable   (state != IDLE),
      .terminal (tmr_term),
      .expire   (tmr_exp)
   );
   always_comb begin
      state_nx      = state;
      occ_nx        = occ;
      last_entry_nx = last_entry;
      timeout_nx    = 1'b0;
      if (arb) begin
         state_nx      = pick_entry ? OPEN_ENTRY : bus.exit_req ? OPEN_EXIT : IDLE;
         last_entry_nx = pick_entry ? 1'b1 : bus.exit_req ? 1'b0 : last_entry;
      end else if (state == OPEN_ENTRY && bus.entry_pass) begin
         state_nx = GUARD;
         occ_nx   = occ + 1'b1;
      end else if (state == OPEN_EXIT && bus.exit_pass) begin
         state_nx = GUARD;
         occ_nx   = occ - CNT_W'(occ != '0);
      end else if (state != GUARD && tmr_exp) begin
         state_nx   = GUARD;
         timeout_nx = 1'b1;
      end
   end
   always_ff @(posedge clock_in or negedge rst_in)
      if (!rst_in) begin
         state      <= IDLE;
         occ        <= '0;
         last_entry <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_nx;
         occ        <= occ_nx;
         last_entry <= last_entry_nx;
         timeout_q  <= timeout_nx;
      end
   assign bus.entry_grant = state == OPEN_ENTRY;
   assign bus.exit_grant  = state == OPEN_EXIT;
   assign bus.gate_open   = state == OPEN_ENTRY || state == OPEN_EXIT;
   assign bus.occupancy   = occ;
   assign bus.full        = full;
   assign bus.empty       = occ == '0;
   assign bus.timeout_err = timeout_q;
endmodule
